// File: rtl/majority_pkg.sv
// Shared constants and helpers for the majority voter.
// Vote mode encodings plus the majority level function.
package majority_pkg;

    localparam logic [1:0] MODE_MAJ  = 2'b00;
    localparam logic [1:0] MODE_UNAN = 2'b01;
    localparam logic [1:0] MODE_ANY  = 2'b10;
    localparam logic [1:0] MODE_THR  = 2'b11;

    // Smallest count that is a majority of n inputs.
    function automatic int maj_level(input int n);
        return (n / 2) + 1;
    endfunction

endpackage

// File: rtl/majority_popcount.sv
// Combinational ones-count of an N-bit vector.
// Ports: v (N-bit input), ones (count, $clog2(N+1) bits).
module majority_popcount #(
    parameter int N = 5,
    localparam int PW = $clog2(N + 1)
) (
    input  logic [N-1:0]  v,
    output logic [PW-1:0] ones
);

    always_comb begin
        ones = '0;
        for (int i = 0; i < N; i++) begin
            ones = ones + PW'(v[i]);
        end
    end

endmodule

// File: rtl/majority_voter.sv
// Registered N-input voter: 2-stage pipeline, mode select,
// glitch filter on led, saturating dissent counter, fill valid.
// Ports: clk, rst_n (sync, active-low), en, sw[N], mode[2],
//   thresh, raw_vote, led, popcount, dissent_cnt, valid.
module majority_voter
    import majority_pkg::*;
#(
    parameter int N             = 5,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8,
    localparam int PW           = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N-1:0]     sw,
    input  logic [1:0]       mode,
    input  logic [PW-1:0]    thresh,
    output logic             raw_vote,
    output logic             led,
    output logic [PW-1:0]    popcount,
    output logic [CNT_W-1:0] dissent_cnt,
    output logic             valid
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    logic [N-1:0]  sw_q;
    logic          vote_q;
    logic [PW-1:0] pc_d;
    logic          vote_d;
    logic [CW-1:0] cnt;
    logic [1:0]    fill;
    logic          dis_hit;

    majority_popcount #(.N(N)) u_pc (
        .v    (sw_q),
        .ones (pc_d)
    );

    // Vote function on the stage-2 count; mode/thresh are live inputs.
    always_comb begin
        vote_d = 1'b0;
        unique case (mode)
            MODE_MAJ:  vote_d = int'(pc_d) >= maj_level(N);
            MODE_UNAN: vote_d = int'(pc_d) == N;
            MODE_ANY:  vote_d = pc_d != '0;
            MODE_THR:  vote_d = pc_d >= thresh;
            default:   vote_d = 1'b0;
        endcase
    end

    assign dis_hit  = valid && (popcount != '0) && (int'(popcount) < N);
    assign valid    = fill[1];
    assign raw_vote = vote_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_q        <= '0;
            vote_q      <= 1'b0;
            popcount    <= '0;
            led         <= 1'b0;
            cnt         <= '0;
            dissent_cnt <= '0;
            fill        <= '0;
        end else if (en) begin
            sw_q     <= sw;
            popcount <= pc_d;
            vote_q   <= vote_d;

            // Filter sees the pre-edge vote_q, so a vote toggling on the
            // expiry edge still commits the old value to led.
            if (vote_q == led) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                led <= vote_q;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end

            if (dis_hit && !(&dissent_cnt)) begin
                dissent_cnt <= dissent_cnt + CNT_W'(1);
            end

            if (!fill[1]) begin
                fill <= fill + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_majority_voter.sv
// Directed-vector bench for majority_voter (N=5, STABLE_CYCLES=4).
// A second instance with CNT_W=3 shares inputs for saturation.
module tb_majority_voter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [4:0] sw;
    logic [1:0] mode;
    logic [2:0] thresh;

    logic       raw_vote, led, valid;
    logic [2:0] popcount;
    logic [7:0] dissent_cnt;

    logic       s_raw, s_led, s_valid;
    logic [2:0] s_pc;
    logic [2:0] s_dis;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    majority_voter #(.N(5), .STABLE_CYCLES(4), .CNT_W(8)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .sw          (sw),
        .mode        (mode),
        .thresh      (thresh),
        .raw_vote    (raw_vote),
        .led         (led),
        .popcount    (popcount),
        .dissent_cnt (dissent_cnt),
        .valid       (valid)
    );

    majority_voter #(.N(5), .STABLE_CYCLES(4), .CNT_W(3)) u_sat (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .sw          (sw),
        .mode        (mode),
        .thresh      (thresh),
        .raw_vote    (s_raw),
        .led         (s_led),
        .popcount    (s_pc),
        .dissent_cnt (s_dis),
        .valid       (s_valid)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b1;
        sw     = 5'b11111;
        mode   = 2'b00;
        thresh = 3'd0;

        // Reset
        tick(3);
        check("rst_raw", 32'(raw_vote), 32'd0);
        check("rst_led", 32'(led), 32'd0);
        check("rst_pc", 32'(popcount), 32'd0);
        check("rst_dis", 32'(dissent_cnt), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        rst_n = 1'b1;
        tick(1);
        check("fill1_valid", 32'(valid), 32'd0);
        check("fill1_raw", 32'(raw_vote), 32'd0);
        tick(1);
        check("fill2_valid", 32'(valid), 32'd1);
        check("e1_raw", 32'(raw_vote), 32'd1);
        check("e1_pc", 32'(popcount), 32'd5);
        check("e1_led", 32'(led), 32'd0);
        tick(3);
        check("e4_led", 32'(led), 32'd0);
        tick(1);
        check("e5_led", 32'(led), 32'd1);
        check("unan_dis", 32'(dissent_cnt), 32'd0);

        // Majority boundary
        sw = 5'b00111;
        tick(2);
        check("maj3_pc", 32'(popcount), 32'd3);
        check("maj3_raw", 32'(raw_vote), 32'd1);
        check("maj3_led", 32'(led), 32'd1);
        check("maj3_dis0", 32'(dissent_cnt), 32'd0);
        tick(1);
        check("maj3_dis1", 32'(dissent_cnt), 32'd1);
        sw = 5'b00011;
        tick(2);
        check("maj2_pc", 32'(popcount), 32'd2);
        check("maj2_raw", 32'(raw_vote), 32'd0);
        check("maj2_dis", 32'(dissent_cnt), 32'd3);
        check("maj2_led_e1", 32'(led), 32'd1);
        tick(3);
        check("maj2_led_e4", 32'(led), 32'd1);
        check("maj2_dis_e4", 32'(dissent_cnt), 32'd6);
        tick(1);
        check("maj2_led_e5", 32'(led), 32'd0);
        check("maj2_dis_e5", 32'(dissent_cnt), 32'd7);

        // Glitch rejection, 3 cycles
        sw = 5'b11111;
        tick(8);
        check("steady_led", 32'(led), 32'd1);
        sw = 5'b00001;
        tick(3);
        check("g3_raw_lo", 32'(raw_vote), 32'd0);
        sw = 5'b11111;
        tick(1);
        check("g3_raw_lo2", 32'(raw_vote), 32'd0);
        tick(1);
        check("g3_raw_hi", 32'(raw_vote), 32'd1);
        check("g3_led_a", 32'(led), 32'd1);
        tick(1);
        check("g3_led_b", 32'(led), 32'd1);
        tick(1);
        check("g3_led_c", 32'(led), 32'd1);

        // Glitch of 4 cycles reaches led
        sw = 5'b00001;
        tick(4);
        sw = 5'b11111;
        tick(1);
        check("g4_led_pre", 32'(led), 32'd1);
        tick(1);
        check("g4_led_drop", 32'(led), 32'd0);
        check("g4_raw", 32'(raw_vote), 32'd1);
        tick(3);
        check("g4_led_low", 32'(led), 32'd0);
        tick(1);
        check("g4_led_back", 32'(led), 32'd1);

        // Modes
        mode = 2'b01;
        sw   = 5'b11110;
        tick(2);
        check("unan_pc", 32'(popcount), 32'd4);
        check("unan_vote", 32'(raw_vote), 32'd0);
        mode = 2'b10;
        sw   = 5'b00001;
        tick(2);
        check("any_vote", 32'(raw_vote), 32'd1);
        mode   = 2'b11;
        thresh = 3'd0;
        sw     = 5'b00000;
        tick(2);
        check("thr0_pc", 32'(popcount), 32'd0);
        check("thr0_vote", 32'(raw_vote), 32'd1);
        thresh = 3'd6;
        sw     = 5'b11111;
        tick(2);
        check("thr6_vote", 32'(raw_vote), 32'd0);
        thresh = 3'd3;
        sw     = 5'b10101;
        tick(2);
        check("thr3_vote", 32'(raw_vote), 32'd1);
        thresh = 3'd4;
        tick(1);
        check("thr4_vote", 32'(raw_vote), 32'd0);

        // Enable stall mid-filter
        mode = 2'b00;
        sw   = 5'b11111;
        tick(8);
        check("stall_pre_led", 32'(led), 32'd1);
        sw = 5'b00000;
        tick(4);
        en = 1'b0;
        sw = 5'b11111;
        tick(10);
        check("stall_led", 32'(led), 32'd1);
        check("stall_raw", 32'(raw_vote), 32'd0);
        check("stall_pc", 32'(popcount), 32'd0);
        check("stall_valid", 32'(valid), 32'd1);
        en = 1'b1;
        sw = 5'b00000;
        tick(1);
        check("resume_led1", 32'(led), 32'd1);
        tick(1);
        check("resume_led2", 32'(led), 32'd0);

        // Dissent saturation
        rst_n = 1'b0;
        sw    = 5'b01010;
        tick(2);
        check("sat_rst", 32'(s_dis), 32'd0);
        rst_n = 1'b1;
        tick(8);
        check("sat_e8", 32'(s_dis), 32'd6);
        tick(1);
        check("sat_e9", 32'(s_dis), 32'd7);
        tick(3);
        check("sat_e12", 32'(s_dis), 32'd7);
        check("wide_e12", 32'(dissent_cnt), 32'd10);
        check("sat_pc", 32'(s_pc), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/majority_voter.md
# majority_voter

Parametrised, registered N-input voter with selectable vote mode, a glitch filter and dissent statistics. It is the next generation of the team's fixed 5-switch majority circuit: inputs are sampled into a two-stage pipeline, and the voted result only drives `led` after it has been stable for a configurable number of cycles. It sits between the board switch bank (or redundant channel inputs) and the LED/consumer logic.

## Interface
- `N`, default 5: number of voter inputs; must be ≥3.
- `STABLE_CYCLES`, default 4: consecutive differing votes required before `led` flips; must be ≥1.
- `CNT_W`, default 8: width of the dissent counter.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `en` in 1: clock enable. When 0, all state holds.
- `sw` in N: voter inputs.
- `mode` in 2: vote mode. 00 = majority, 01 = unanimous, 10 = any, 11 = threshold.
- `thresh` in $clog2(N+1): threshold, used only in mode 11.
- `raw_vote` out 1: unfiltered registered vote (`vote_q`).
- `led` out 1: filtered vote.
- `popcount` out $clog2(N+1): registered count of ones in `sw_q`.
- `dissent_cnt` out CNT_W: saturating count of non-unanimous cycles.
- `valid` out 1: pipeline filled since the last reset.

## Operation
- **Stage 1:** on an enabled edge, `sw_q <= sw`.
- **Stage 2:** on an enabled edge, `popcount <= ones(sw_q)` and `vote_q <= f(ones(sw_q), mode, thresh)`. `mode` and `thresh` are read combinationally at this stage and are not registered separately.
- **Vote function f(p):**
  - majority: p ≥ (N/2)+1 (integer division; for odd N this is a strict majority).
  - unanimous: p == N.
  - any: p ≥ 1.
  - threshold: p ≥ `thresh`. `thresh` = 0 gives constant 1; `thresh` > N gives constant 0.
- **Filter:** counter `cnt`, width $clog2(STABLE_CYCLES+1). On each enabled edge, evaluated in order:
  - if `vote_q` == `led`: `cnt <= 0`.
  - else if `cnt` == STABLE_CYCLES−1: `led <= vote_q`, `cnt <= 0`.
  - else: `cnt <= cnt+1`.
- A `vote_q` glitch shorter than STABLE_CYCLES enabled cycles never reaches `led`. Any return to agreement clears `cnt`.
- **Dissent:** on an enabled edge with `valid`=1 and 0 < `popcount` < N, `dissent_cnt` increments. It saturates at 2^CNT_W−1 and does not wrap.
- **valid:** a 2-bit fill counter that advances on enabled edges. `valid` = 1 from the second enabled edge after reset onward.
- **en = 0:** `sw_q`, `vote_q`, `popcount`, `cnt`, `led`, `dissent_cnt` and the fill counter all hold.

## Timing
- Reset (`rst_n`=0 at an edge): `sw_q`, `vote_q`, `raw_vote`, `led`, `popcount`, `dissent_cnt`, `cnt`, fill counter and `valid` all become 0. Reset overrides `en`.
- Reset mid-filter discards the partial count; `led` returns to 0.
- Latency, with `en` held high:
  - `sw` captured at edge E.
  - `raw_vote` and `popcount` update at E+1.
  - `led` flips at edge E+1+STABLE_CYCLES, provided the vote stays constant.
- Latency counts enabled edges only; disabled cycles stretch it without resetting `cnt`.
- `mode`/`thresh` change: takes effect at the next enabled edge through stage 2, then passes through the filter like any input change.
- Simultaneous `vote_q` toggle and filter expiry: the comparison uses the pre-edge `vote_q`, so `led` takes the old `vote_q` value. The filter then re-evaluates against the new value.

## Structure
- Package `majority_pkg`:
  - mode constants `MODE_MAJ`=2'b00, `MODE_UNAN`=2'b01, `MODE_ANY`=2'b10, `MODE_THR`=2'b11.
  - function `maj_level(N)` returning (N/2)+1.
- Sub-module `majority_popcount`, parametrised by N: purely combinational ones-count of an N-bit vector, instantiated in stage 2.
- Top-level contents: pipeline, vote function, filter, dissent counter and fill counter.

## Test plan
All scenarios use N=5, STABLE_CYCLES=4, `en`=1 unless stated.
- **Reset:** hold `rst_n`=0 for 3 cycles with `sw`=5'b11111 → all outputs 0. Release → `valid`=1 after 2 edges; `raw_vote`=1 at E+1; `led`=1 at E+5.
- **Majority boundary:** `sw`=5'b00111 → `popcount`=3, `led`=1. `sw`=5'b00011 → `popcount`=2, `led` falls 5 edges after capture. `dissent_cnt` increments every cycle in both cases.
- **Glitch rejection:** from steady `led`=1, apply `sw`=5'b00001 for 3 cycles, then restore 5'b11111 → `raw_vote` pulses low for 3 cycles; `led` stays 1. Repeat with 4 cycles → `led` drops for exactly the 4th-to-last window.
- **Modes:**
  - mode 01 with `sw`=5'b11110 → vote 0.
  - mode 10 with `sw`=5'b00001 → vote 1.
  - mode 11 with `thresh`=0 → 1 for `sw`=0.
  - mode 11 with `thresh`=6 → 0 for `sw`=5'b11111.
- **Enable stall:** drop `en` for 10 cycles mid-filter with `cnt`=2 → all outputs frozen. Re-raise `en` → `led` flips after 2 further enabled edges.
- **Dissent saturation:** with CNT_W=3, apply `sw`=5'b01010 for 12 cycles → `dissent_cnt` stops at 7.
